rv32_muldiv_unit: RTL and testbench
===================================

RV32_MULDIV_UNIT -- requirements
Module: rv32_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter DIV_STEPS, default 1, quotient bits resolved per cycle; legal values 1, 2 and 4; must divide XLEN.
REQ-003 Parameter TAG_W, default 5, request tag width (destination register index).
REQ-004 clk  in  1  clock; all state on posedge.
REQ-005 resetn  in  1  reset, asynchronous, active-high (asserted = 1).
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  unit accepts request this cycle.
REQ-008 req_op  in  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 req_op1 / req_op2  in  XLEN each  rs1 / rs2 operand (post-bypass).
REQ-010 req_tag  in  TAG_W  opaque tag, returned with result.
REQ-011 flush  in  1  kill in-flight operation (branch taken / trap).
REQ-012 resp_valid  out  1  result available.
REQ-013 resp_ready  in  1  consumer takes result.
REQ-014 resp_result  out  XLEN  result; resp_tag  out  TAG_W  tag of the operation.
REQ-015 busy  out  1  high whenever state is not IDLE; used by hazard unit to stall issue.

Function
REQ-016 FSM states IDLE, CALC, DONE; req_ready = (state == IDLE) and not flush.
REQ-017 Acceptance: req_valid and req_ready at posedge latches op, operands, tag; IDLE -> CALC, or IDLE -> DONE for single-cycle cases.
REQ-018 Division: restoring, on magnitudes, DIV_STEPS bits/cycle; CALC lasts XLEN/DIV_STEPS cycles, then DONE; signs fixed up on entry to DONE.
REQ-019 Signed rules: quotient negative iff operand signs differ and divisor nonzero; remainder takes dividend's sign.
REQ-020 Divide by zero: single-cycle, IDLE -> DONE; DIV/DIVU = all ones, REM/REMU = dividend.
REQ-021 Signed overflow (DIV/REM, op1 = most-negative, op2 = -1): single-cycle; DIV = op1, REM = 0.
REQ-022 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-023 In DONE: resp_valid = 1; resp_result and resp_tag held stable until resp_ready; on resp_ready, DONE -> IDLE; no new request accepted in that same cycle.
REQ-024 flush has priority over all events: any state -> IDLE at next posedge; resp_valid low from that edge; a request presented with flush is not accepted.
REQ-025 resp_valid never asserted in IDLE or CALC; exactly one response per accepted, unflushed request.

Reset
REQ-026 While resetn asserted: state = IDLE, resp_valid = 0, busy = 0, resp_result = 0, resp_tag = 0, all datapath registers cleared; takes effect without a clock edge.
REQ-027 Reset mid-CALC or mid-DONE discards the operation; no response is produced after release.

Configuration
REQ-028 Macro RV32_MULDIV_FAST_MUL_EN defined: multiply ops go IDLE -> DONE with a single-cycle combinational XLEN x XLEN multiplier (response one cycle after acceptance).
REQ-029 Macro not defined: multiply ops use shift-add in CALC for XLEN/DIV_STEPS cycles, sharing the divider adder; results bit-identical to the fast variant.

Verification
REQ-030 XLEN=32, DIV_STEPS=1: DIV op1=-7 (0xFFFFFFF9), op2=2, tag=3 -> after 32 CALC cycles resp_valid=1, result 0xFFFFFFFD, resp_tag=3; REM same operands -> 0xFFFFFFFF.
REQ-031 DIVU op1=0x1234, op2=0 -> resp_valid on next cycle, result 0xFFFFFFFF; REMU same operands -> 0x1234.
REQ-032 DIV op1=0x80000000, op2=0xFFFFFFFF -> result 0x80000000 in one cycle; REM same operands -> 0.
REQ-033 MULH op1=0x80000000, op2=0x80000000 -> 0x40000000; MULHSU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001; run with and without RV32_MULDIV_FAST_MUL_EN.
REQ-034 resp_ready held low 5 cycles in DONE -> result and tag stable and req_ready=0 throughout; flush at CALC cycle 10 -> IDLE next edge, no resp_valid; next request completes normally.
REQ-035 Async resetn pulse mid-CALC between clock edges -> busy=0, resp_valid=0 immediately; DIV_STEPS=4 run completes DIV in 8 CALC cycles.

Source files
------------

// File: rtl/rv32_muldiv_unit.sv
// RV32/RV64 M-extension multiply/divide unit: restoring divider and shift-add multiplier on one shared adder.
// Optional macro RV32_MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier instead.
module rv32_muldiv_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DIV_STEPS = 1,
    parameter int unsigned TAG_W     = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_op1,
    input  logic [XLEN-1:0]  req_op2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned CYCLES = XLEN / DIV_STEPS;
    localparam int unsigned CNT_W  = $clog2(CYCLES);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_result;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic             r_neg;
    logic             r_neg_r;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_div;
    logic             w_s1;
    logic             w_s2;
    logic             w_n1;
    logic             w_n2;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic             w_div0;
    logic             w_ovf;
    logic [XLEN-1:0]  w_quick;

    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_x;
    logic [XLEN:0]     w_y;
    logic [XLEN+1:0]   w_sum;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_fin;

    assign req_ready   = (r_state == S_IDLE) && !flush;
    assign resp_valid  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign resp_result = r_result;
    assign resp_tag    = r_tag;

    // Operand signedness: divides are signed unless funct3[0]; MULH signs both, MULHSU only rs1
    assign w_is_div = req_op[2];
    assign w_s1     = w_is_div ? ~req_op[0] : (req_op[1] ^ req_op[0]);
    assign w_s2     = w_is_div ? ~req_op[0] : (req_op[1:0] == 2'b01);
    assign w_n1     = w_s1 & req_op1[XLEN-1];
    assign w_n2     = w_s2 & req_op2[XLEN-1];
    assign w_mag1   = w_n1 ? -req_op1 : req_op1;
    assign w_mag2   = w_n2 ? -req_op2 : req_op2;
    assign w_div0   = w_is_div && (req_op2 == '0);
    assign w_ovf    = w_is_div && !req_op[0] && (req_op1 == MOST_NEG) && (req_op2 == '1);
    assign w_quick  = w_div0 ? (req_op[1] ? req_op1 : '1) : (req_op[1] ? '0 : req_op1);

`ifdef RV32_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fmul;
    logic [2*XLEN-1:0] w_fmul_s;
    logic [XLEN-1:0]   w_fres;

    assign w_fmul   = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fmul_s = (w_n1 ^ w_n2) ? -w_fmul : w_fmul;
    assign w_fres   = (req_op[1:0] == 2'b00) ? w_fmul_s[XLEN-1:0] : w_fmul_s[2*XLEN-1:XLEN];
`endif

    // One shared adder per step: subtract divisor (restoring) or add multiplicand (shift-add, LSB first)
    always_comb begin
        w_hi  = r_hi;
        w_lo  = r_lo;
        w_x   = '0;
        w_y   = '0;
        w_sum = '0;
        for (int unsigned i = 0; i < DIV_STEPS; i++) begin
            if (r_op[2]) begin
                w_x   = {w_hi, w_lo[XLEN-1]};
                w_y   = ~{1'b0, r_b};
                w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(XLEN+1){1'b0}}, 1'b1};
                w_lo  = {w_lo[XLEN-2:0], w_sum[XLEN+1]};
                w_hi  = w_sum[XLEN+1] ? w_sum[XLEN-1:0] : w_x[XLEN-1:0];
            end else begin
                w_x   = {1'b0, w_hi};
                w_y   = w_lo[0] ? {1'b0, r_b} : '0;
                w_sum = {1'b0, w_x} + {1'b0, w_y};
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end
        end
    end

    assign w_quo    = r_neg ? -w_lo : w_lo;
    assign w_rem    = r_neg_r ? -w_hi : w_hi;
    assign w_prod   = {w_hi, w_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_fin    = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                    : ((r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op  <= req_op;
                        r_tag <= req_tag;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_quick;
                            r_state  <= S_DONE;
                        end
`ifdef RV32_MULDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_result <= w_fres;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            // Divider: dividend in lo, divisor in b. Multiplier: multiplier in lo, multiplicand in b
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? w_mag1 : w_mag2;
                            r_b     <= w_is_div ? w_mag2 : w_mag1;
                            r_neg   <= w_n1 ^ w_n2;
                            r_neg_r <= w_n1;
                            r_cnt   <= CNT_W'(CYCLES - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_hi;
                    r_lo  <= w_lo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_fin;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Randomised self-checking bench for rv32_muldiv_unit against a plain-arithmetic RV M reference.
`timescale 1ns/1ps
module tb_rv32_muldiv_unit;

`ifdef RV32_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;
    logic        busy;

    logic        d4_req_valid = 1'b0;
    logic        d4_req_ready;
    logic [2:0]  d4_req_op = '0;
    logic [31:0] d4_req_op1 = '0;
    logic [31:0] d4_req_op2 = '0;
    logic        d4_resp_valid;
    logic        d4_resp_ready = 1'b0;
    logic [31:0] d4_resp_result;
    logic [4:0]  d4_resp_tag;
    logic        d4_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32_muldiv_unit #(.XLEN(32), .DIV_STEPS(1), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
    );

    rv32_muldiv_unit #(.XLEN(32), .DIV_STEPS(4), .TAG_W(5)) dut4 (
        .clk(clk), .resetn(resetn), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
        .req_op(d4_req_op), .req_op1(d4_req_op1), .req_op2(d4_req_op2), .req_tag(5'd17),
        .flush(1'b0), .resp_valid(d4_resp_valid), .resp_ready(d4_resp_ready),
        .resp_result(d4_resp_result), .resp_tag(d4_resp_tag), .busy(d4_busy)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        int          ia, ib, r;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                r = ia / ib;
                return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                r = ia % ib;
                return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // CALC cycles between acceptance and DONE; 0 means the response follows acceptance directly
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int calc);
        if (op[2] && (b == 0 || (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF))) return 0;
        if (!op[2] && FAST) return 0;
        return calc;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN32;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold, output logic [31:0] res);
        int          n;
        logic [31:0] r0;
        logic [4:0]  t0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_op1 = a; req_op2 = b; req_tag = tag;
        check_eq("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, ref_lat(op, a, b, 32));
        check_eq("result", resp_result, ref_result(op, a, b));
        check_eq("tag", resp_tag, tag);
        res = resp_result;
        r0  = resp_result;
        t0  = resp_tag;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_op = 3'd5; req_op1 = $urandom; req_op2 = 32'd3; req_tag = ~tag;
            check_eq("req_ready_done", req_ready, 0);
            @(posedge clk); #1;
            check_eq("hold_valid", resp_valid, 1);
            check_eq("hold_result", resp_result, r0);
            check_eq("hold_tag", resp_tag, t0);
        end
        req_valid = 1'b1; req_op = 3'd5; req_op1 = $urandom; req_op2 = 32'd3;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check_eq("drain_valid", resp_valid, 0);
        check_eq("drain_not_accepted", busy, 0);
    endtask

    task automatic run4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        d4_req_valid = 1'b1; d4_req_op = op; d4_req_op1 = a; d4_req_op2 = b;
        check_eq("d4_ready", d4_req_ready, 1);
        @(posedge clk); #1;
        d4_req_valid = 1'b0;
        n = 0;
        while (!d4_resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("d4_latency", n, ref_lat(op, a, b, 8));
        check_eq("d4_result", d4_resp_result, ref_result(op, a, b));
        check_eq("d4_tag", d4_resp_tag, 17);
        d4_resp_ready = 1'b1;
        @(posedge clk); #1;
        d4_resp_ready = 1'b0;
        check_eq("d4_busy_after", d4_busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          seen;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_result", resp_result, 0);
        check_eq("rst_tag", resp_tag, 0);
        #11 resetn = 1'b0;

        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, res);
        check_eq("div_neg7_by2", res, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, res);
        check_eq("rem_neg7_by2", res, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h1234, 32'd0, 5'd4, 0, res);
        check_eq("divu_by0", res, 32'hFFFF_FFFF);
        run_op(3'd7, 32'h1234, 32'd0, 5'd4, 0, res);
        check_eq("remu_by0", res, 32'h1234);
        run_op(3'd4, MIN32, 32'hFFFF_FFFF, 5'd5, 0, res);
        check_eq("div_ovf", res, MIN32);
        run_op(3'd6, MIN32, 32'hFFFF_FFFF, 5'd5, 0, res);
        check_eq("rem_ovf", res, 32'd0);
        run_op(3'd1, MIN32, MIN32, 5'd6, 0, res);
        check_eq("mulh_min", res, 32'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, res);
        check_eq("mulhsu_m1", res, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, res);
        check_eq("mulhu_max", res, 32'hFFFF_FFFE);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, res);
        check_eq("mul_m1", res, 32'h0000_0001);
        run_op(3'd4, 32'd1000, 32'd7, 5'd9, 5, res);

        // Flush in the tenth CALC cycle, with a competing request on the same cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_op1 = 32'd12345; req_op2 = 32'd11; req_tag = 5'd12;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check_eq("flush_pre_busy", busy, 1);
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd5;
        check_eq("flush_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_valid", resp_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        check_eq("flush_no_resp", seen, 0);
        run_op(3'd6, 32'd12345, 32'd11, 5'd13, 0, res);

        // Asynchronous reset between clock edges mid-CALC
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; req_op1 = 32'hDEAD_BEEF; req_op2 = 32'd77; req_tag = 5'd21;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 resetn = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_valid", resp_valid, 0);
        check_eq("arst_result", resp_result, 0);
        check_eq("arst_tag", resp_tag, 0);
        @(posedge clk); #2;
        resetn = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        check_eq("arst_no_resp", seen, 0);

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 5'($urandom),
                   $urandom_range(0, 2), res);
        end

        run4(3'd4, 32'hFFFF_FFF9, 32'd2);
        check_eq("d4_div_neg7", d4_resp_result, 32'hFFFF_FFFD);
        for (int i = 0; i < 12; i++) begin
            run4(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
